// File: rtl/filter_ctrl_pkg.sv
// Shared definitions for the switched-cap filter phase/event controller:
// sequencer state codes and the event record pushed into the readout FIFO.
package filter_ctrl_pkg;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_P1   = 3'd1;
  localparam logic [2:0] ST_D12  = 3'd2;
  localparam logic [2:0] ST_P2   = 3'd3;
  localparam logic [2:0] ST_D21  = 3'd4;

  localparam int EVT_TS_W = 16;

  typedef struct packed {
    logic                pol;
    logic [EVT_TS_W-1:0] ts;
  } evt_t;
endpackage

// File: rtl/event_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
module event_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/filter_phase_event_ctrl.sv
// Two-phase non-overlapping clock sequencer for the switched-cap comparator macro,
// plus frame-end sampling of the comparator into a timestamped event FIFO.
module filter_phase_event_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int TS_W        = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          en,
  input  logic [DIV_W-1:0]              half_period,
  input  logic [DIV_W-1:0]              dead_time,
  output logic                          phi1,
  output logic                          phi2,
  output logic                          phi1b,
  output logic                          phi2b,
  input  logic                          compout_i,
  input  logic                          pol_i,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [TS_W:0]                 evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   evt_count,
  output logic                          evt_ovf,
  input  logic                          ovf_clr
);
  logic [2:0]             state;
  logic [DIV_W-1:0]       cnt, hp_l, dt_l, hp_eff, dt_eff;
  logic [SYNC_STAGES-1:0] comp_pipe, pol_pipe;
  logic [TS_W-1:0]        ts;
  logic                   frame_end, push, pop, fifo_empty, fifo_full;

  assign hp_eff    = (half_period == '0) ? DIV_W'(1) : half_period;
  assign dt_eff    = (dead_time   == '0) ? DIV_W'(1) : dead_time;
  assign frame_end = (state == ST_D21) && (cnt == '0);

  // cnt holds remaining cycles minus one in the current phase.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      hp_l  <= DIV_W'(1);
      dt_l  <= DIV_W'(1);
    end else begin
      case (state)
        ST_IDLE: if (en) begin
          state <= ST_P1;
          hp_l  <= hp_eff;
          dt_l  <= dt_eff;
          cnt   <= hp_eff - DIV_W'(1);
        end
        ST_P1: if (cnt == '0) begin
          state <= ST_D12;
          cnt   <= dt_l - DIV_W'(1);
        end else cnt <= cnt - DIV_W'(1);
        ST_D12: if (cnt == '0) begin
          state <= ST_P2;
          cnt   <= hp_l - DIV_W'(1);
        end else cnt <= cnt - DIV_W'(1);
        ST_P2: if (cnt == '0) begin
          state <= ST_D21;
          cnt   <= dt_l - DIV_W'(1);
        end else cnt <= cnt - DIV_W'(1);
        ST_D21: if (cnt == '0) begin
          if (en) begin
            state <= ST_P1;
            hp_l  <= hp_eff;
            dt_l  <= dt_eff;
            cnt   <= hp_eff - DIV_W'(1);
          end else begin
            state <= ST_IDLE;
          end
        end else cnt <= cnt - DIV_W'(1);
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      phi1  <= 1'b0;
      phi2  <= 1'b0;
      phi1b <= 1'b1;
      phi2b <= 1'b1;
    end else begin
      phi1  <= (state == ST_P1);
      phi2  <= (state == ST_P2);
      phi1b <= (state != ST_P1);
      phi2b <= (state != ST_P2);
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      comp_pipe <= '0;
      pol_pipe  <= '0;
      ts        <= '0;
      evt_ovf   <= 1'b0;
    end else begin
      comp_pipe <= {comp_pipe[SYNC_STAGES-2:0], compout_i};
      pol_pipe  <= {pol_pipe[SYNC_STAGES-2:0], pol_i};
      if (frame_end) ts <= ts + TS_W'(1);
      // A fresh drop wins over a clear in the same cycle.
      if (push && fifo_full && !pop) evt_ovf <= 1'b1;
      else if (ovf_clr)              evt_ovf <= 1'b0;
    end
  end

  assign push      = frame_end & comp_pipe[SYNC_STAGES-1];
  assign pop       = evt_valid & evt_ready;
  assign evt_valid = ~fifo_empty;

  event_fifo #(.W(TS_W+1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push),
    .push_data ({pol_pipe[SYNC_STAGES-1], ts}),
    .pop       (pop),
    .head      (evt_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (evt_count)
  );
endmodule
